// File: rtl/intellight_axil_regbank.sv
// AXI4-Lite register bank: byte-strobe writes, self-clearing START, read-only status.
// Build option: INTELLIGHT_REGBANK_SLVERR_EN returns SLVERR for out-of-range accesses.
module intellight_axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic                           start_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef INTELLIGHT_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  wstate_e w_state_q, w_state_d;
  rstate_e r_state_q, r_state_d;
  logic    run_q;
  logic    aw_done_q, aw_done_d;
  logic    w_done_q, w_done_d;
  idx_t    aw_idx_q, aw_idx_d;
  word_t   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d;
  word_t   regs_q [NUM_REGS];
  word_t   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic    start_q, start_d;
  word_t   rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, w_open;
  idx_t ar_idx;
  logic unused_ok;

  // In W_RESP the address/data channels reopen on the BREADY cycle,
  // which is what allows one write every two cycles.
  assign w_open        = run_q && ((w_state_q == W_IDLE) || S_AXI_BREADY);
  assign S_AXI_AWREADY = w_open && !aw_done_q;
  assign S_AXI_WREADY  = w_open && !w_done_q;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = run_q && (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = wr_pulse_q;
  assign start_pulse   = start_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:OFF_W];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    start_d    = 1'b0;
    if (aw_hs) begin
      aw_done_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:OFF_W];
    end
    if (w_hs) begin
      w_done_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_done_q && w_done_q) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bresp_d   = RESP_OOR;
          // The status slot is read-only: acknowledged, never stored.
          for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(aw_idx_q) == k) begin
              bresp_d = RESP_OKAY;
              if (k != NUM_REGS - 1) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                end
                if (k == 0) begin
                  start_d      = wstrb_q[0] & wdata_q[0];
                  regs_d[k][0] = 1'b0;
                end
              end
            end
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_OOR;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(ar_idx) == k) begin
              rresp_d = RESP_OKAY;
              if (k == NUM_REGS - 1) rdata_d = status_in;
              else rdata_d = regs_q[k];
            end
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      run_q      <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      wr_pulse_q <= '0;
      start_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      run_q      <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      start_q    <= start_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_intellight_axil_regbank.sv
// Bench for intellight_axil_regbank: two instances (8 and 6 registers),
// randomized traffic, reference model feeding response queues checked by a monitor.
module tb_intellight_axil_regbank;
`ifdef INTELLIGHT_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct packed {
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic        start;
    logic        chk;
    logic [2:0]  idx;
    logic [31:0] val;
  } bexp_t;
  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  awaddr[2], araddr[2];
  logic        awvalid[2], wvalid[2], bready[2], arvalid[2], rready[2];
  logic [31:0] wdata[2], st[2];
  logic [3:0]  wstrb[2];
  logic        awready[2], wready[2], bvalid[2], arready[2], rvalid[2], startp[2];
  logic [1:0]  bresp[2], rresp[2];
  logic [31:0] rdata[2];
  logic [255:0] ro0;
  logic [191:0] ro1;
  logic [7:0]  wrp0;
  logic [5:0]  wrp1;
  logic [255:0] ro[2];
  logic [7:0]  wrp[2];
  logic [2:0]  prot;

  assign ro[0]  = ro0;
  assign ro[1]  = {64'b0, ro1};
  assign wrp[0] = wrp0;
  assign wrp[1] = {2'b0, wrp1};

  intellight_axil_regbank u_dut0 (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid[0]),
    .S_AXI_AWREADY(awready[0]), .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]),
    .S_AXI_WVALID(wvalid[0]), .S_AXI_WREADY(wready[0]), .S_AXI_BRESP(bresp[0]),
    .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready[0]), .S_AXI_ARADDR(araddr[0]),
    .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]), .S_AXI_RVALID(rvalid[0]),
    .S_AXI_RREADY(rready[0]), .reg_out(ro0), .reg_wr_pulse(wrp0),
    .start_pulse(startp[0]), .status_in(st[0])
  );

  intellight_axil_regbank #(.DATA_WIDTH(32), .NUM_REGS(6), .ADDR_WIDTH(5)) u_dut1 (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid[1]),
    .S_AXI_AWREADY(awready[1]), .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]),
    .S_AXI_WVALID(wvalid[1]), .S_AXI_WREADY(wready[1]), .S_AXI_BRESP(bresp[1]),
    .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready[1]), .S_AXI_ARADDR(araddr[1]),
    .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]), .S_AXI_RVALID(rvalid[1]),
    .S_AXI_RREADY(rready[1]), .reg_out(ro1), .reg_wr_pulse(wrp1),
    .start_pulse(startp[1]), .status_in(st[1])
  );

  int n_cmp = 0;
  int n_fail = 0;
  int nreg[2] = '{8, 6};
  logic [31:0] mem[2][8];
  bexp_t bq0[$], bq1[$];
  rexp_t rq0[$], rq1[$];
  int pcnt[2], scnt[2], epc[2], esc[2];
  bit bfirst[2], rfirst[2];

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", nm, d, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) mem[d][k] = '0;
  endtask

  task automatic model_write(input int d, input logic [4:0] a,
                             input logic [31:0] v, input logic [3:0] s);
    bexp_t e;
    int idx;
    idx = int'(a) / 4;
    e = '0;
    if (idx >= nreg[d]) begin
      e.resp = OOR;
    end else if (idx < nreg[d] - 1) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem[d][idx][8*b +: 8] = v[8*b +: 8];
      if (idx == 0) begin
        e.start = s[0] & v[0];
        mem[d][0][0] = 1'b0;
      end
      e.pulse = 8'(1 << idx);
      e.chk = 1'b1;
      e.idx = 3'(idx);
      e.val = mem[d][idx];
    end
    epc[d] += (e.pulse != 0) ? 1 : 0;
    esc[d] += int'(e.start);
    if (d == 0) bq0.push_back(e);
    else bq1.push_back(e);
  endtask

  task automatic model_read(input int d, input logic [4:0] a);
    rexp_t e;
    int idx;
    idx = int'(a) / 4;
    if (idx >= nreg[d]) e = '{OOR, 32'h0};
    else if (idx == nreg[d] - 1) e = '{2'b00, st[d]};
    else e = '{2'b00, mem[d][idx]};
    if (d == 0) rq0.push_back(e);
    else rq1.push_back(e);
  endtask

  task automatic mon(input int d);
    bexp_t be;
    rexp_t re;
    pcnt[d] += $countones(wrp[d]);
    scnt[d] += int'(startp[d]);
    if (bvalid[d] && !bfirst[d]) begin
      bfirst[d] = 1'b1;
      if ((d == 0 && bq0.size() == 0) || (d == 1 && bq1.size() == 0)) begin
        n_fail++;
        $display("FAIL b_unexpected dut%0d", d);
      end else begin
        if (d == 0) be = bq0.pop_front();
        else be = bq1.pop_front();
        chk("bresp", d, 32'(bresp[d]), 32'(be.resp));
        chk("wr_pulse", d, 32'(wrp[d]), 32'(be.pulse));
        chk("start_pulse", d, 32'(startp[d]), 32'(be.start));
        if (be.chk) chk("reg_out", d, ro[d][int'(be.idx)*32 +: 32], be.val);
      end
    end
    if (bvalid[d] && bready[d]) bfirst[d] = 1'b0;
    if (rvalid[d] && !rfirst[d]) begin
      rfirst[d] = 1'b1;
      if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
        n_fail++;
        $display("FAIL r_unexpected dut%0d", d);
      end else begin
        if (d == 0) re = rq0.pop_front();
        else re = rq1.pop_front();
        chk("rdata", d, rdata[d], re.data);
        chk("rresp", d, 32'(rresp[d]), 32'(re.resp));
      end
    end
    if (rvalid[d] && rready[d]) rfirst[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bfirst = '{1'b0, 1'b0};
      rfirst = '{1'b0, 1'b0};
    end else begin
      mon(0);
      mon(1);
    end
  end

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic axi_write(input int d, input logic [4:0] a, input logic [31:0] v,
                           input logic [3:0] s, input int lead, input bit hold);
    bit aw_ok, w_ok, done;
    int t;
    model_write(d, a, v, s);
    aw_ok = 0; w_ok = 0; t = 0;
    awaddr[d] = a; wdata[d] = v; wstrb[d] = s;
    while (!(aw_ok && w_ok) && t < 100) begin
      awvalid[d] = !aw_ok && (t >= lead);
      wvalid[d]  = !w_ok && (t >= -lead);
      @(negedge clk);
      if (awvalid[d] && awready[d]) aw_ok = 1;
      if (wvalid[d] && wready[d]) w_ok = 1;
      @(posedge clk); #1;
      t++;
    end
    awvalid[d] = 0; wvalid[d] = 0;
    if (!(aw_ok && w_ok)) begin
      n_fail++;
      $display("FAIL aw_w_timeout dut%0d", d);
    end
    t = 0; done = 0;
    while (!done && t < 100) begin
      bready[d] = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bvalid[d] && (hold || bready[d])) done = 1;
      @(posedge clk); #1;
      t++;
    end
    bready[d] = 0;
    if (!done) begin
      n_fail++;
      $display("FAIL b_timeout dut%0d", d);
    end
  endtask

  task automatic axi_read(input int d, input logic [4:0] a);
    bit ok;
    int t;
    ok = 0; t = 0;
    araddr[d] = a;
    while (!ok && t < 100) begin
      arvalid[d] = 1'b1;
      @(negedge clk);
      if (arready[d]) begin
        ok = 1;
        model_read(d, a);
      end
      @(posedge clk); #1;
      t++;
    end
    arvalid[d] = 0;
    ok = 0; t = 0;
    while (!ok && t < 100) begin
      rready[d] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (rvalid[d] && rready[d]) ok = 1;
      @(posedge clk); #1;
      t++;
    end
    rready[d] = 0;
    if (!ok) begin
      n_fail++;
      $display("FAIL r_timeout dut%0d", d);
    end
  endtask

  initial begin
    logic [255:0] exp_flat;
    int d, k;
    prot = 3'b000;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; araddr[i] = '0; awvalid[i] = 0; wvalid[i] = 0;
      bready[i] = 0; arvalid[i] = 0; rready[i] = 0; wdata[i] = '0;
      wstrb[i] = '0; pcnt[i] = 0; scnt[i] = 0; epc[i] = 0; esc[i] = 0;
    end
    st[0] = 32'hCAFE0001;
    st[1] = 32'h5A5A0006;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 0, {29'b0, awready[0], wready[0], arready[0]}, 32'h0);
    chk("reset_valid", 0, {30'b0, bvalid[0], rvalid[0]}, 32'h0);
    chk("reset_regs", 0, 32'(|ro[0]), 32'h0);
    chk("reset_outs", 0, {23'b0, startp[0], wrp[0]}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) axi_read(0, 5'(4 * i));
    for (int i = 1; i <= 6; i++) axi_write(0, 5'(4 * i), 32'h11111110 + i, 4'hF, 0, 0);
    for (int i = 1; i <= 6; i++) axi_read(0, 5'(4 * i));
    axi_write(0, 5'h08, 32'h0, 4'hF, 0, 0);
    axi_write(0, 5'h08, 32'hAABBCCDD, 4'b0101, 0, 0);
    axi_read(0, 5'h08);
    axi_write(0, 5'h00, 32'h00000003, 4'hF, 2, 0);
    axi_read(0, 5'h00);
    axi_write(0, 5'h0C, 32'h12345678, 4'h0, -1, 0);
    axi_write(0, 5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_read(0, 5'h1C);

    axi_write(1, 5'h08, 32'h0BADF00D, 4'hF, 0, 0);
    axi_write(1, 5'h1C, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(1, 5'h1C);
    axi_write(1, 5'h18, 32'hDEADBEEF, 4'hF, 1, 0);
    axi_read(1, 5'h18);
    axi_read(1, 5'h14);
    axi_read(1, 5'h08);

    for (int i = 0; i < 60; i++) begin
      d = (i % 4 == 3) ? 1 : 0;
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 5) == 0) st[d] = $urandom;
      if ($urandom_range(0, 1) == 0)
        axi_write(d, 5'(4 * k) | 5'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, 0);
      else
        axi_read(d, 5'(4 * k));
    end

    axi_write(0, 5'h10, 32'h77777777, 4'hF, 0, 1);
    rst = 1'b1;
    #1;
    chk("rst_bvalid", 0, 32'(bvalid[0]), 32'h0);
    chk("rst_regs", 0, 32'(|ro[0]), 32'h0);
    chk("rst_regs", 1, 32'(|ro[1]), 32'h0);
    model_clear();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    axi_write(0, 5'h04, 32'h0000BEEF, 4'hF, 0, 0);
    axi_read(0, 5'h04);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_flat = '0;
      for (int r = 0; r < 8; r++)
        if (r < nreg[i]) exp_flat[r*32 +: 32] = mem[i][r];
      for (int r = 0; r < 8; r++)
        chk("final_reg_out", i, ro[i][r*32 +: 32], exp_flat[r*32 +: 32]);
      chk("pulse_count", i, pcnt[i], epc[i]);
      chk("start_count", i, scnt[i], esc[i]);
    end
    chk("queues_drained", 0, bq0.size() + bq1.size() + rq0.size() + rq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/intellight_axil_regbank.md
# intellight_axil_regbank

Parametrised AXI4-Lite slave register bank for the Intellight accelerator. It replaces the fixed four-register slave interface with a configurable number and width of registers, byte-strobe writes, a self-clearing START control bit and a read-only status register. It sits between the PS AXI interconnect and the accelerator core: it exposes all registers as a flat bus and takes the core's status word back in.

## Interface
- DATA_WIDTH, 32: register and AXI data width. Legal values: 32 or 64.
- NUM_REGS, 8: number of registers. Legal range: 2..64.
- ADDR_WIDTH, 5: AXI address width. Must be at least clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
- ACLK  in  1  sole clock; all logic is on the rising edge.
- ARESET  in  1  reset, asynchronous and active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address channel.
- S_AXI_WDATA  in  DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address channel.
- S_AXI_RDATA  out  DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.
- AWPROT and ARPROT are accepted and ignored.
- reg_out  out  NUM_REGS*DATA_WIDTH: flat register contents. Register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS: one-cycle strobe for each register written.
- start_pulse  out  1: one-cycle pulse when START is written as 1.
- status_in  in  DATA_WIDTH: accelerator status word, mapped to register NUM_REGS-1.

## Operation
- Address decode:
  - index = ADDR[ADDR_WIDTH-1 : clog2(DATA_WIDTH/8)]; the lower byte-offset bits are ignored.
  - An index >= NUM_REGS is out of range.
- Register 0 (control):
  - bit0 is START. Writing 1 to it asserts start_pulse. START always reads 0 and always appears as 0 on reg_out.
  - All other bits of register 0 are read/write.
- Registers 1..NUM_REGS-2 are read/write.
- Register NUM_REGS-1 is read-only:
  - Reads return status_in, sampled at the AR handshake edge.
  - Writes are dropped but still complete with OKAY. No reg_wr_pulse is generated.
- Byte strobes: only byte lanes whose WSTRB bit is set are updated. WSTRB=0 completes the transaction and still generates reg_wr_pulse.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AWREADY and WREADY are each 1 until their own channel has been captured. AW and W may arrive in either order or in the same cycle.
  - Once both are captured: perform the write, then enter W_RESP.
  - In W_RESP, hold BVALID until BREADY, then return to W_IDLE.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, ARREADY=1. On the AR handshake, register RDATA and RRESP and enter R_DATA.
  - In R_DATA, hold RVALID, RDATA and RRESP stable until RREADY, then return to R_IDLE.
- Read and write channels are independent and may be active in the same cycle. A read on the same edge as a write to the same register returns the old value.
- Reset mid-transaction: both FSMs return to idle immediately, all registers clear, and any in-flight transaction is abandoned with no response.

## Timing
- Reset values: every output is 0, including AWREADY, WREADY, ARREADY and all registers. The ready signals rise on the first edge after ARESET deasserts.
- Write latency:
  - Let edge N be the edge at which both AW and W are held.
  - At edge N+1: the register updates, BVALID=1, and reg_wr_pulse[k]/start_pulse go high for exactly one cycle.
  - AWREADY and WREADY are 0 from the edge at which their own channel is captured until BVALID completes.
- Read latency: an AR handshake at edge N gives RVALID=1 with valid data after edge N. ARREADY=0 while RVALID=1.
- Back-to-back throughput: one write per 2 cycles and one read per 2 cycles when BREADY and RREADY are held high.

## Configuration
- INTELLIGHT_REGBANK_SLVERR_EN defined: any out-of-range access returns SLVERR (2'b10); out-of-range reads also return RDATA=0.
- INTELLIGHT_REGBANK_SLVERR_EN undefined: out-of-range accesses return OKAY and RDATA=0.
- In both cases, out-of-range writes change no state and generate no pulse.

## Test plan
- Reset, then read every register. Expect RDATA=0 and RRESP=OKAY for registers 0..NUM_REGS-2. For register NUM_REGS-1, expect the current status_in (drive 0xCAFE0001).
- Defaults (DATA_WIDTH=32, NUM_REGS=8): write 0x11111110+k to addresses 0x04..0x18, then read back. Expect exact values, and one reg_wr_pulse per write.
- Write 0xAABBCCDD to 0x08 with WSTRB=0b0101 over an existing value 0x00000000. Expect a readback of 0x00BB00DD.
- Drive W two cycles before AW, writing 0x00000003 to address 0x00. Expect:
  - one cycle of start_pulse;
  - reg_out[31:0]=0x00000002;
  - readback of 0x00000002.
- With NUM_REGS=6, read and write address 0x1C. Expect SLVERR when INTELLIGHT_REGBANK_SLVERR_EN is defined and OKAY when it is not, RDATA=0 in both builds, and no state change.
- Assert ARESET while BVALID=1 and BREADY=0. Expect:
  - BVALID=0 immediately;
  - all registers 0;
  - a subsequent write to 0x04 completes normally with BRESP=OKAY.
